// File: rtl/xpb_pkg.sv
// -----------------------------------------------------------------------------
// xpb_pkg
// Shared definitions for the xpb reduction lookup-table arbiter slice.
//   XPB_IDX_W   : width of an xpb table index
//   XPB_DATA_W  : width of an xpb table value
//   XPB_ID_W    : widest requester tag carried through the pipeline (16 req.)
//   xpb_idx_t   : table index type
//   xpb_tag_t   : {vld, id} tag that follows a lookup through the table latency
//   onehot_to_id: encodes a (zero-extended) one-hot grant into a requester id
// -----------------------------------------------------------------------------
package xpb_pkg;

    localparam int XPB_IDX_W  = 5;
    localparam int XPB_DATA_W = 1024;
    localparam int XPB_ID_W   = 4;

    typedef logic [XPB_IDX_W-1:0] xpb_idx_t;

    typedef struct packed {
        logic                vld;
        logic [XPB_ID_W-1:0] id;
    } xpb_tag_t;

    // OR-encode so a one-hot input never builds a priority chain
    function automatic logic [XPB_ID_W-1:0] onehot_to_id(input logic [15:0] oh);
        logic [XPB_ID_W-1:0] id_v;
        id_v = {XPB_ID_W{1'b0}};
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                id_v = id_v | XPB_ID_W'(i);
            end else begin
                id_v = id_v;
            end
        end
        return id_v;
    endfunction

endpackage

// File: rtl/rr_arbiter_oh.sv
// -----------------------------------------------------------------------------
// rr_arbiter_oh
// Round-robin arbiter with a one-hot grant. The search starts at the pointer
// and wraps; after a grant to i the pointer moves to (i+1) mod NUM_REQ, and it
// holds when nothing is granted.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset (pointer -> 0, grant forced low)
//   en    : arbitration enable (low while the pipeline is being flushed)
//   req   : request vector
//   grant : one-hot grant, combinational, subset of req
// -----------------------------------------------------------------------------
module rr_arbiter_oh #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]     ptr_r;
    logic [PTR_W-1:0]     ptr_nxt_s;
    logic [NUM_REQ-1:0]   req_gated_s;
    logic [2*NUM_REQ-1:0] req_rot_dbl_s;
    logic [NUM_REQ-1:0]   req_rot_s;
    logic [NUM_REQ-1:0]   gnt_rot_s;
    logic [2*NUM_REQ-1:0] gnt_dbl_s;
    logic [NUM_REQ-1:0]   grant_s;

    // Rotate requests so the pointer sits at bit 0, isolate the lowest set
    // bit (first requester at or after the pointer), then rotate back.
    always_comb begin
        req_gated_s   = req & {NUM_REQ{en & ~rst}};
        req_rot_dbl_s = {req_gated_s, req_gated_s} >> ptr_r;
        req_rot_s     = req_rot_dbl_s[NUM_REQ-1:0];
        gnt_rot_s     = req_rot_s & (~req_rot_s + NUM_REQ'(1));
        gnt_dbl_s     = {gnt_rot_s, gnt_rot_s} << ptr_r;
        grant_s       = gnt_dbl_s[2*NUM_REQ-1:NUM_REQ];
    end

    // Next pointer: one past the granted requester, wrapping to 0
    always_comb begin
        ptr_nxt_s = ptr_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                ptr_nxt_s = (i == NUM_REQ - 1) ? {PTR_W{1'b0}} : PTR_W'(i + 1);
            end else begin
                ptr_nxt_s = ptr_nxt_s;
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= {PTR_W{1'b0}};
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/xpb_lut_arbiter.sv
// -----------------------------------------------------------------------------
// xpb_lut_arbiter
// Time-shares one registered xpb reduction table among NUM_REQ requesters.
// One round-robin grant per cycle drives the registered table index; a
// {vld,id} tag follows the lookup through 1+LUT_LAT stages so the returned
// table value is registered and tagged with its requester id.
// Latency from handshake to rsp_valid is 2+LUT_LAT cycles; responses come back
// in grant order with no backpressure.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid    : per-requester lookup request
//   req_idx      : flattened indices, requester i at [i*IDX_W +: IDX_W]
//   req_ready    : one-hot grant (combinational)
//   flush        : drop all in-flight lookups, block new grants this cycle
//   lut_idx      : registered index to the shared table
//   lut_data     : table output, valid LUT_LAT cycles after lut_idx
//   rsp_valid    : single-cycle result pulse
//   rsp_id       : owner of rsp_data
//   rsp_data     : registered table value
//   stat_grants  : per-requester 32-bit saturating grant counters
// Build option: define XPB_ARB_STATS_EN to build the grant counters;
// otherwise stat_grants is tied to zero.
// -----------------------------------------------------------------------------
module xpb_lut_arbiter
    import xpb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int IDX_W   = XPB_IDX_W,
    parameter int DATA_W  = XPB_DATA_W,
    parameter int LUT_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    flush,
    output logic [IDX_W-1:0]        lut_idx,
    input  logic [DATA_W-1:0]       lut_data,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [NUM_REQ*32-1:0]   stat_grants
);

    logic [NUM_REQ-1:0]  grant_s;
    logic                any_grant_s;
    logic [XPB_ID_W-1:0] grant_id_s;
    logic [IDX_W-1:0]    sel_idx_s;
    logic [IDX_W-1:0]    lut_idx_r;
    xpb_tag_t            tag_pipe_r [LUT_LAT+1];
    xpb_tag_t            tag_last_s;
    logic                rsp_valid_r;
    logic [ID_W-1:0]     rsp_id_r;
    logic [DATA_W-1:0]   rsp_data_r;

    rr_arbiter_oh #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (~flush),
        .req   (req_valid),
        .grant (grant_s)
    );

    // Grant decode: any-grant flag, granted id and the granted requester's index
    always_comb begin
        any_grant_s = |grant_s;
        grant_id_s  = onehot_to_id(16'(grant_s));
        sel_idx_s   = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                sel_idx_s = sel_idx_s | req_idx[i*IDX_W +: IDX_W];
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
        tag_last_s = tag_pipe_r[LUT_LAT];
    end

    // Table index register and tag pipeline; flush clears every valid bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lut_idx_r <= {IDX_W{1'b0}};
            for (int s = 0; s <= LUT_LAT; s++) begin
                tag_pipe_r[s] <= '0;
            end
        end else begin
            if (any_grant_s) begin
                lut_idx_r <= sel_idx_s;
            end else begin
                lut_idx_r <= lut_idx_r;
            end
            // flush already suppresses the grant, so stage 0 is empty then
            tag_pipe_r[0] <= '{vld: any_grant_s, id: grant_id_s};
            for (int s = 1; s <= LUT_LAT; s++) begin
                if (flush) begin
                    tag_pipe_r[s] <= '0;
                end else begin
                    tag_pipe_r[s] <= tag_pipe_r[s-1];
                end
            end
        end
    end

    // Response registers; id/data hold between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {ID_W{1'b0}};
            rsp_data_r  <= {DATA_W{1'b0}};
        end else begin
            if (tag_last_s.vld && !flush) begin
                rsp_valid_r <= 1'b1;
                rsp_id_r    <= ID_W'(tag_last_s.id);
                rsp_data_r  <= lut_data;
            end else begin
                rsp_valid_r <= 1'b0;
                rsp_id_r    <= rsp_id_r;
                rsp_data_r  <= rsp_data_r;
            end
        end
    end

`ifdef XPB_ARB_STATS_EN
    logic [31:0] stat_cnt_r [NUM_REQ];

    // Saturating per-requester grant counters, cleared only by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_s[i] && (stat_cnt_r[i] != 32'hFFFF_FFFF)) begin
                    stat_cnt_r[i] <= stat_cnt_r[i] + 32'd1;
                end else begin
                    stat_cnt_r[i] <= stat_cnt_r[i];
                end
            end
        end
    end

    // Flatten counters onto the stats bus
    always_comb begin
        stat_grants = {(NUM_REQ*32){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*32 +: 32] = stat_cnt_r[i];
        end
    end
`else
    assign stat_grants = {(NUM_REQ*32){1'b0}};
`endif

    assign req_ready = grant_s;
    assign lut_idx   = lut_idx_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;

endmodule
